// File: rtl/uart_rx_cfg_if.sv
// Bus between the baud-tick/config side and the configurable UART receiver.
// The master drives the line, the tick and the per-frame configuration;
// the slave (the receiver) returns the frame result.
interface uart_rx_cfg_if;
  logic       rx;
  logic       s_tick;
  logic [1:0] dbit_sel;
  logic [1:0] par_mode;
  logic [1:0] stop_sel;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;

  modport master (
    output rx, s_tick, dbit_sel, par_mode, stop_sel,
    input  rx_done_tick, dout, parity_err, frame_err, break_det
  );

  modport slave (
    input  rx, s_tick, dbit_sel, par_mode, stop_sel,
    output rx_done_tick, dout, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: OVS-times oversampling, 3-sample
// majority vote per bit, 5..8 data bits, none/even/odd parity, 1/1.5/2 stop
// bits, start-glitch rejection, and per-frame parity/framing/break flags.
module uart_rx_cfg #(
  parameter int OVS = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_rx_cfg_if.slave bus
);

  localparam int SW = $clog2(2 * OVS);
  localparam logic [SW-1:0] S_HALF   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V0     = SW'(OVS - 3);
  localparam logic [SW-1:0] S_V1     = SW'(OVS - 2);
  localparam logic [SW-1:0] S_LAST   = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP15 = SW'(3 * OVS / 2 - 1);
  localparam logic [SW-1:0] S_STOP2  = SW'(2 * OVS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_e;

  // Majority of three line samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Even-parity reduction of the received data byte.
  function automatic logic xor8(input logic [7:0] v);
    return ^v;
  endfunction

  logic          sync1_q, rxs_q;
  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [1:0]    vote_q, vote_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    dsel_q, dsel_d, pmode_q, pmode_d, ssel_q, ssel_d;
  logic          par_vote_q, par_vote_d, stop_vote_q, stop_vote_d;
  logic          done_q, done_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic [7:0]    dout_q, dout_d;

  logic [2:0]    samp_s;
  logic          bit_s, in_win_s, par_en_s, first_stop_s;
  logic [2:0]    last_n_s;
  logic [SW-1:0] stop_end_s;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      rxs_q   <= sync1_q;
    end
  end

  // Receiver state, counters, latched configuration and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= 3'd0;
      vote_q      <= 2'b00;
      data_q      <= 8'h00;
      dsel_q      <= 2'b00;
      pmode_q     <= 2'b00;
      ssel_q      <= 2'b00;
      par_vote_q  <= 1'b0;
      stop_vote_q <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= 8'h00;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      vote_q      <= vote_d;
      data_q      <= data_d;
      dsel_q      <= dsel_d;
      pmode_q     <= pmode_d;
      ssel_q      <= ssel_d;
      par_vote_q  <= par_vote_d;
      stop_vote_q <= stop_vote_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
    end
  end

  // Next-state logic: tick-driven bit recovery and end-of-frame reporting.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    vote_d      = vote_q;
    data_d      = data_q;
    dsel_d      = dsel_q;
    pmode_d     = pmode_q;
    ssel_d      = ssel_q;
    par_vote_d  = par_vote_q;
    stop_vote_d = stop_vote_q;
    done_d      = 1'b0;
    dout_d      = dout_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;

    samp_s   = {vote_q, rxs_q};
    bit_s    = maj3(samp_s);
    in_win_s = (s_q == S_V0) || (s_q == S_V1) || (s_q == S_LAST);
    par_en_s = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    last_n_s = 3'd4 + {1'b0, dsel_q};
    // With one stop bit the final tick is also the vote tick, so use the live vote.
    first_stop_s = (s_q == S_LAST) ? bit_s : stop_vote_q;
    case (ssel_q)
      2'b00:   stop_end_s = S_LAST;
      2'b01:   stop_end_s = S_STOP15;
      default: stop_end_s = S_STOP2;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          s_d     = '0;
          data_d  = 8'h00;
          dsel_d  = bus.dbit_sel;
          pmode_d = bus.par_mode;
          ssel_d  = bus.stop_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bus.s_tick) begin
          if (s_q == S_HALF) begin
            if (!rxs_q) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_DATA, ST_PARITY: begin
        if (bus.s_tick) begin
          if (in_win_s) begin
            vote_d = {vote_q[0], rxs_q};
          end else begin
            vote_d = vote_q;
          end
          if (s_q == S_LAST) begin
            s_d = '0;
            if (state_q == ST_PARITY) begin
              par_vote_d = bit_s;
              state_d    = ST_STOP;
            end else begin
              data_d[n_q] = bit_s;
              if (n_q == last_n_s) begin
                state_d = par_en_s ? ST_PARITY : ST_STOP;
              end else begin
                n_d = n_q + 3'd1;
              end
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_STOP: begin
        if (bus.s_tick) begin
          if (in_win_s) begin
            vote_d = {vote_q[0], rxs_q};
          end else begin
            vote_d = vote_q;
          end
          if (s_q == S_LAST) begin
            stop_vote_d = bit_s;
          end else begin
            stop_vote_d = stop_vote_q;
          end
          if (s_q == stop_end_s) begin
            done_d  = 1'b1;
            dout_d  = data_q;
            ferr_d  = ~first_stop_s;
            perr_d  = par_en_s && ((xor8(data_q) ^ par_vote_q) != (pmode_q == 2'b10));
            brk_d   = (data_q == 8'h00) && (!par_en_s || !par_vote_q) && !first_stop_s;
            s_d     = '0;
            state_d = first_stop_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
  assign bus.break_det    = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: OVS=16, s_tick every 4 clk, one task per scenario.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset;
  uart_rx_cfg_if bus ();

  uart_rx_cfg #(.OVS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tick_abs = 0;
  int cap_tick = 0;
  int start_tick = 0;
  logic [1:0] tdiv = 2'd0;
  logic [7:0] cap_dout = 8'h00;
  logic [2:0] cap_flags = 3'b000;

  // Tick generator: one-clk strobe every fourth clock, changed on negedge.
  always @(negedge clk) begin
    tdiv       <= tdiv + 2'd1;
    bus.s_tick <= (tdiv == 2'd3);
  end

  // Absolute tick counter as seen by the DUT at the active edge.
  always @(posedge clk) begin
    if (bus.s_tick === 1'b1) tick_abs <= tick_abs + 1;
  end

  // Record every completion pulse and the outputs present with it.
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      cap_dout  <= bus.dout;
      cap_flags <= {bus.parity_err, bus.frame_err, bus.break_det};
      cap_tick  <= tick_abs;
    end
  end

  task automatic hold(input logic lvl, input int nclk);
    bus.rx = lvl;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic align();
    do @(posedge clk); while (bus.s_tick !== 1'b1);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] d, input logic [1:0] p, input logic [1:0] s);
    bus.dbit_sel = d;
    bus.par_mode = p;
    bus.stop_sel = s;
  endtask

  // par: 0 none, 1 even, 2 odd. glitch_bit: data bit that gets a 1-tick low pulse.
  task automatic send_frame(input logic [7:0] data, input int nbits, input int par,
                            input bit flip, input int stop_clk, input int glitch_bit);
    logic pb;
    start_tick = tick_abs;
    hold(1'b0, 64);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit && data[i]) begin
        hold(1'b1, 28);
        hold(1'b0, 4);
        hold(1'b1, 32);
      end else begin
        hold(data[i], 64);
      end
    end
    if (par != 0) begin
      pb = 1'b0;
      for (int i = 0; i < nbits; i++) pb = pb ^ data[i];
      if (par == 2) pb = ~pb;
      if (flip) pb = ~pb;
      hold(pb, 64);
    end
    hold(1'b1, stop_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx = 1'b1;
    set_cfg(2'b11, 2'b00, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.rx_done_tick, bus.dout, bus.parity_err, bus.frame_err, bus.break_det} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 000",
               {bus.rx_done_tick, bus.dout, bus.parity_err, bus.frame_err, bus.break_det});
    end
    reset = 1'b0;
    hold(1'b1, 20);
  endtask

  task automatic test_back_to_back();
    int base;
    set_cfg(2'b11, 2'b00, 2'b00);
    base = done_cnt;
    align();
    send_frame(8'h55, 8, 0, 1'b0, 64, -1);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL b2b_count1 got %0d expected %0d", done_cnt, base + 1); end
    checks++;
    if (cap_dout !== 8'h55) begin errors++; $display("FAIL b2b_dout1 got %h expected 55", cap_dout); end
    checks++;
    if (cap_flags !== 3'b000) begin errors++; $display("FAIL b2b_flags1 got %b expected 000", cap_flags); end
    checks++;
    if (cap_tick - start_tick !== 152) begin errors++; $display("FAIL b2b_ticks got %0d expected 152", cap_tick - start_tick); end
    send_frame(8'hA3, 8, 0, 1'b0, 64, -1);
    checks++;
    if (done_cnt !== base + 2) begin errors++; $display("FAIL b2b_count2 got %0d expected %0d", done_cnt, base + 2); end
    checks++;
    if (cap_dout !== 8'hA3) begin errors++; $display("FAIL b2b_dout2 got %h expected a3", cap_dout); end
    checks++;
    if (cap_flags !== 3'b000) begin errors++; $display("FAIL b2b_flags2 got %b expected 000", cap_flags); end
  endtask

  task automatic test_parity();
    int base;
    set_cfg(2'b10, 2'b01, 2'b00);
    base = done_cnt;
    align();
    send_frame(8'h41, 7, 1, 1'b0, 64, -1);
    checks++;
    if (cap_dout !== 8'h41) begin errors++; $display("FAIL par_dout_ok got %h expected 41", cap_dout); end
    checks++;
    if (cap_flags !== 3'b000) begin errors++; $display("FAIL par_flags_ok got %b expected 000", cap_flags); end
    send_frame(8'h41, 7, 1, 1'b1, 64, -1);
    checks++;
    if (cap_dout !== 8'h41) begin errors++; $display("FAIL par_dout_bad got %h expected 41", cap_dout); end
    checks++;
    if (cap_flags !== 3'b100) begin errors++; $display("FAIL par_flags_bad got %b expected 100", cap_flags); end
    checks++;
    if (done_cnt !== base + 2) begin errors++; $display("FAIL par_count got %0d expected %0d", done_cnt, base + 2); end
  endtask

  task automatic test_5o2();
    int base;
    set_cfg(2'b00, 2'b10, 2'b10);
    base = done_cnt;
    align();
    send_frame(8'h1B, 5, 2, 1'b0, 128, -1);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL 5o2_count got %0d expected %0d", done_cnt, base + 1); end
    checks++;
    if (cap_dout !== 8'h1B) begin errors++; $display("FAIL 5o2_dout got %h expected 1b", cap_dout); end
    checks++;
    if (cap_flags !== 3'b000) begin errors++; $display("FAIL 5o2_flags got %b expected 000", cap_flags); end
    checks++;
    if (cap_tick - start_tick !== 136) begin errors++; $display("FAIL 5o2_ticks got %0d expected 136", cap_tick - start_tick); end
  endtask

  task automatic test_break();
    int base;
    set_cfg(2'b11, 2'b00, 2'b00);
    base = done_cnt;
    align();
    hold(1'b0, 20 * 64);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL brk_count_low got %0d expected %0d", done_cnt, base + 1); end
    checks++;
    if ({cap_dout, cap_flags} !== 11'b00000000_011) begin
      errors++; $display("FAIL brk_result got %h/%b expected 00/011", cap_dout, cap_flags);
    end
    hold(1'b1, 128);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL brk_count_high got %0d expected %0d", done_cnt, base + 1); end
  endtask

  task automatic test_glitch();
    int base;
    set_cfg(2'b11, 2'b00, 2'b00);
    base = done_cnt;
    align();
    hold(1'b0, 16);
    hold(1'b1, 128);
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL glitch_start_count got %0d expected %0d", done_cnt, base); end
    checks++;
    if ({bus.dout, bus.frame_err, bus.break_det} !== 10'b00000000_11) begin
      errors++; $display("FAIL glitch_start_hold got %h/%b%b expected 00/11", bus.dout, bus.frame_err, bus.break_det);
    end
    align();
    send_frame(8'h55, 8, 0, 1'b0, 64, 0);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL glitch_data_count got %0d expected %0d", done_cnt, base + 1); end
    checks++;
    if (cap_dout !== 8'h55) begin errors++; $display("FAIL glitch_data_dout got %h expected 55", cap_dout); end
    checks++;
    if (cap_flags !== 3'b000) begin errors++; $display("FAIL glitch_data_flags got %b expected 000", cap_flags); end
  endtask

  task automatic test_reset_abort();
    int base;
    set_cfg(2'b11, 2'b00, 2'b00);
    base = done_cnt;
    align();
    hold(1'b0, 64);
    hold(1'b1, 192);
    reset = 1'b1;
    hold(1'b1, 3);
    checks++;
    if ({bus.rx_done_tick, bus.dout, bus.parity_err, bus.frame_err, bus.break_det} !== 12'h000) begin
      errors++;
      $display("FAIL abort_outputs got %h expected 000",
               {bus.rx_done_tick, bus.dout, bus.parity_err, bus.frame_err, bus.break_det});
    end
    reset = 1'b0;
    hold(1'b1, 64 * 7);
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL abort_no_done got %0d expected %0d", done_cnt, base); end
    align();
    send_frame(8'h3C, 8, 0, 1'b0, 64, -1);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL abort_next_count got %0d expected %0d", done_cnt, base + 1); end
    checks++;
    if (cap_dout !== 8'h3C) begin errors++; $display("FAIL abort_next_dout got %h expected 3c", cap_dout); end
    checks++;
    if (cap_flags !== 3'b000) begin errors++; $display("FAIL abort_next_flags got %b expected 000", cap_flags); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_5o2();
    test_break();
    test_glitch();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
